// File: rtl/abs_diff_sweep_ctrl.sv
// Exhaustive sweep sequencer for one approximate |a-b| netlist: drives every input
// vector, grades each response against the exact |a-b| and keeps worst-case error statistics.
module abs_diff_sweep_ctrl #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 3,
    parameter int ET    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [IN_W-1:0]   approx_in,
    input  logic [OUT_W-1:0]  approx_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [OUT_W-1:0]  max_err,
    output logic [IN_W:0]     err_count,
    output logic              fail_valid,
    output logic [IN_W-1:0]   fail_vec
);

    localparam int              HALF     = IN_W / 2;
    localparam logic [IN_W-1:0]  LAST_VEC = '1;
    localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   vec_q, vec_d;
    logic [OUT_W-1:0]  err_q, err_d;
    logic [IN_W-1:0]   vq_q, vq_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [OUT_W-1:0]  max_err_q, max_err_d;
    logic [IN_W:0]     err_count_q, err_count_d;
    logic              fail_valid_q, fail_valid_d;
    logic [IN_W-1:0]   fail_vec_q, fail_vec_d;

    logic [HALF-1:0]   op_a, op_b, op_diff;
    logic [OUT_W-1:0]  exact, err;

    // Golden model: exact |a-b|, then the distance of the DUT response from it.
    always_comb begin
        op_a    = vec_q[HALF-1:0];
        op_b    = vec_q[IN_W-1:HALF];
        op_diff = (op_a > op_b) ? (op_a - op_b) : (op_b - op_a);
        exact   = OUT_W'(op_diff);
        err     = (exact > approx_out) ? (exact - approx_out) : (approx_out - exact);
    end

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        err_d        = err_q;
        vq_d         = vq_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        max_err_d    = max_err_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;

        // The registered error of the previous vector is folded in regardless of state,
        // so the last vector lands during DRAIN and a partial sweep keeps what it saw.
        if (valid_q) begin
            if (err_q > max_err_q) begin
                max_err_d = err_q;
            end
            if (err_q != '0) begin
                err_count_d = err_count_q + (IN_W+1)'(1);
            end
            if ((err_q > ET_V) && !fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_vec_d   = vq_q;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_SWEEP;
                    busy_d       = 1'b1;
                    vec_d        = '0;
                    err_d        = '0;
                    vq_d         = '0;
                    valid_d      = 1'b0;
                    max_err_d    = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    vec_d   = '0;
                end else begin
                    err_d   = err;
                    vq_d    = vec_q;
                    valid_d = 1'b1;
                    if (vec_q == LAST_VEC) begin
                        state_d = S_DRAIN;
                        vec_d   = '0;
                    end else begin
                        vec_d = vec_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                vec_d   = '0;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vec_q        <= '0;
            err_q        <= '0;
            vq_q         <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            max_err_q    <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            err_q        <= err_d;
            vq_q         <= vq_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            max_err_q    <= max_err_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
        end
    end

    // vec_q is held at zero outside SWEEP, so it doubles as the registered DUT drive.
    assign approx_in  = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign max_err    = max_err_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign pass       = (max_err_q <= ET_V);

endmodule

// File: tb/tb_abs_diff_sweep_ctrl.sv
// Directed bench for abs_diff_sweep_ctrl: a behavioural approximate DUT (ideal, stuck-at-0,
// exact+1) is graded by the sequencer and the results compared with hand-computed values.
module tb_abs_diff_sweep_ctrl;

    localparam int IN_W  = 4;
    localparam int OUT_W = 3;
    localparam int ET    = 1;

    localparam int M_IDEAL = 0;
    localparam int M_STUCK = 1;
    localparam int M_PLUS1 = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [IN_W-1:0]   approx_in;
    logic [OUT_W-1:0]  approx_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [OUT_W-1:0]  max_err;
    logic [IN_W:0]     err_count;
    logic              fail_valid;
    logic [IN_W-1:0]   fail_vec;

    int mode = M_IDEAL;
    int n_pass = 0;
    int n_total = 0;
    int done_total = 0;

    abs_diff_sweep_ctrl #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ET    (ET)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .approx_in  (approx_in),
        .approx_out (approx_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .max_err    (max_err),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    always #5 clk = ~clk;

    // Behavioural approximate netlist under characterisation.
    logic [1:0] m_a, m_b, m_ex;
    always_comb begin
        m_a  = approx_in[1:0];
        m_b  = approx_in[3:2];
        m_ex = (m_a > m_b) ? (m_a - m_b) : (m_b - m_a);
        case (mode)
            M_STUCK: approx_out = '0;
            M_PLUS1: approx_out = OUT_W'(m_ex) + 3'd1;
            default: approx_out = OUT_W'(m_ex);
        endcase
    end

    always @(negedge clk) begin
        if (done) done_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int e_max, input int e_cnt,
                                 input int e_fv, input int e_fvec, input int e_pass);
        check({tag, "_max_err"},    32'(max_err),    32'(e_max));
        check({tag, "_err_count"},  32'(err_count),  32'(e_cnt));
        check({tag, "_fail_valid"}, 32'(fail_valid), 32'(e_fv));
        check({tag, "_fail_vec"},   32'(fail_vec),   32'(e_fvec));
        check({tag, "_pass"},       32'(pass),       32'(e_pass));
    endtask

    // Full sweep from IDLE; optional start pulses during SWEEP and in the DONE cycle.
    task automatic run_sweep(input string tag, input int m, input int e_max, input int e_cnt,
                             input int e_fv, input int e_fvec, input int e_pass, input bit glitch);
        int done_base;
        int vec_bad;
        mode      = m;
        done_base = done_total;
        vec_bad   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        for (int v = 0; v < 16; v++) begin
            if (approx_in !== IN_W'(v)) begin
                check({tag, "_approx_in_step"}, 32'(approx_in), 32'(v));
                vec_bad++;
            end
            start = (glitch && v == 3);
            step();
        end
        start = 1'b0;
        check({tag, "_vec_errors"}, 32'(vec_bad), 32'd0);
        check({tag, "_busy_drain"}, 32'(busy), 32'd1);
        check({tag, "_done_early"}, 32'(done), 32'd0);
        step();
        check({tag, "_done_at_17"}, 32'(done), 32'd1);
        check({tag, "_busy_at_17"}, 32'(busy), 32'd0);
        start = glitch;
        step();
        start = 1'b0;
        check({tag, "_done_at_18"}, 32'(done), 32'd0);
        check({tag, "_busy_at_18"}, 32'(busy), 32'd0);
        step();
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check({tag, "_done_pulses"}, 32'(done_total - done_base), 32'd1);
        check_results(tag, e_max, e_cnt, e_fv, e_fvec, e_pass);
    endtask

    initial begin
        int done_base;

        #12;
        check("rst_approx_in", 32'(approx_in), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check_results("rst", 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_sweep("ideal", M_IDEAL, 0, 0, 0, 0, 1, 1'b0);
        // Stuck-at-0: err = exact; 12 vectors with a != b, first err > 1 at a=2,b=0.
        run_sweep("stuck", M_STUCK, 3, 12, 1, 2, 0, 1'b0);
        // exact+1: every vector off by exactly ET, so nothing exceeds the threshold.
        run_sweep("plus1", M_PLUS1, 1, 16, 0, 0, 1, 1'b0);

        // Abort while vector 5 is presented: vectors 0..4 (errs 0,1,2,3,1) are accumulated.
        mode = M_STUCK;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("abort_vec5", 32'(approx_in), 32'd5);
        done_base = done_total;
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_approx_in", 32'(approx_in), 32'd0);
        check("abort_max_err",    32'(max_err),    32'd3);
        check("abort_err_count",  32'(err_count),  32'd4);
        check("abort_fail_valid", 32'(fail_valid), 32'd1);
        check("abort_fail_vec",   32'(fail_vec),   32'd2);
        repeat (25) step();
        check("abort_no_done", 32'(done_total - done_base), 32'd0);
        check("abort_still_idle", 32'(busy), 32'd0);

        // Restart after abort must re-clear; stray starts are ignored.
        run_sweep("restart", M_IDEAL, 0, 0, 0, 0, 1, 1'b1);

        // Reset in the middle of a failing sweep.
        mode = M_STUCK;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("prereset_busy", 32'(busy), 32'd1);
        done_base = done_total;
        rst_n = 1'b0;
        #1;
        check("midrst_approx_in", 32'(approx_in), 32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_done",      32'(done),      32'd0);
        check_results("midrst", 0, 0, 0, 0, 1);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (25) step();
        check("postrst_no_done", 32'(done_total - done_base), 32'd0);
        check("postrst_busy",    32'(busy), 32'd0);

        run_sweep("final", M_STUCK, 3, 12, 1, 2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/abs_diff_sweep_ctrl.md
# abs_diff_sweep_ctrl

Sequencer that exhaustively exercises one approximate absolute-difference netlist (combinational, operands packed in one input vector) and grades it in silicon against an internally computed exact |a−b|. It drives every input vector in order, registers the per-vector error, and accumulates worst-case error, mismatch count and first threshold violation. It sits beside the approximated DUT in the error-characterisation harness and replaces a software sweep for the same error-threshold (ET) check.

## Interface
- IN_W, 4, DUT input width; even; operand a = vec[IN_W/2-1:0], b = vec[IN_W-1:IN_W/2]
- OUT_W, 3, DUT output width; must be ≥ IN_W/2 (ERR_W = OUT_W)
- ET, 1, error threshold; a vector fails when err > ET

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  cancel sweep; sampled in SWEEP/DRAIN
- approx_in  out  IN_W  vector driven to DUT
- approx_out  in  OUT_W  DUT response, combinational from approx_in
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  one-cycle pulse on completion
- pass  out  1  max_err ≤ ET; valid from done until next start
- max_err  out  OUT_W  worst |exact − approx| over sweep
- err_count  out  IN_W+1  vectors with err ≠ 0
- fail_valid  out  1  at least one vector had err > ET
- fail_vec  out  IN_W  first (lowest) vector with err > ET; 0 if none

## Operation
- One clock, asynchronous active-low reset; all flops cleared on rst_n low.
- States: IDLE → SWEEP → DRAIN → DONE → IDLE.
- IDLE: approx_in = 0. start=1 → clear max_err, err_count, fail_valid, fail_vec, err pipeline; vec ← 0; go SWEEP.
- SWEEP: approx_in = vec. Each cycle: exact = |a − b| (unsigned, IN_W/2 bits, zero-extended to OUT_W); err = |exact − approx_out| in OUT_W bits, no wrap; err_q ← err, vq_q ← vec, valid_q ← 1; vec ← vec+1. When vec = 2^IN_W − 1 is sampled → DRAIN.
- Accumulate (any state, when valid_q): max_err ← max(max_err, err_q); err_count += (err_q ≠ 0); if err_q > ET and !fail_valid: fail_valid ← 1, fail_vec ← vq_q.
- DRAIN: valid_q ← 0 after final accumulate; go DONE.
- DONE: done=1 for one cycle; go IDLE. Results held until next start.
- pass = (max_err ≤ ET), combinational from held max_err.
- abort=1 in SWEEP/DRAIN → IDLE next edge, valid_q ← 0, no done, results frozen partial, pass meaningless. abort has priority over state advance. abort ignored in IDLE/DONE.
- start while busy or in DONE: ignored. start and abort simultaneous in IDLE: start wins.
- vec counter never wraps within a sweep; err_count cannot overflow (max 2^IN_W).

## Timing
- Reset values: approx_in=0, busy=0, done=0, max_err=0, err_count=0, fail_valid=0, fail_vec=0, pass=1.
- Edge E0 samples start: busy=1 and approx_in=0 after E0.
- Vector v presented cycle after E0+v; its error registered at E0+v+1, accumulated at E0+v+2.
- 2^IN_W SWEEP cycles, 1 DRAIN, 1 DONE: for IN_W=4, DRAIN after E0+16, done=1 after E0+17 (busy=0 same edge), IDLE after E0+18.
- Start-to-done latency 2^IN_W + 1 cycles; back-to-back start accepted the cycle after done.
- Reset mid-sweep: immediate return to reset values, no done.

## Test plan
- Ideal DUT (approx_out = exact), IN_W=4: done exactly 17 cycles after start edge; max_err=0, err_count=0, fail_valid=0, pass=1; approx_in steps 0..15.
- approx_out stuck at 0, ET=1: max_err=3, err_count=12, fail_valid=1, fail_vec=2 (a=2,b=0), pass=0.
- approx_out = exact+1 (saturating not applied, OUT_W=3): max_err=1, err_count=16, fail_valid=0, pass=1 (err = ET boundary).
- abort at cycle 5 of SWEEP: busy drops next edge, no done pulse; subsequent start re-clears results and full sweep matches ideal case.
- start pulsed during SWEEP and in DONE cycle: ignored, single done; rst_n low at cycle 8: all outputs to reset values asynchronously, no done after release.
